// File: rtl/lcd_frame_ctrl.sv
// HD44780-style 2x16 character LCD controller: power-up init, 32-byte frame buffer,
// and full-frame streaming to the panel with generated E-pulse timing.
module lcd_frame_ctrl #(
   parameter int T_PWR = 70,
   parameter int T_SU  = 1,
   parameter int T_EH  = 2,
   parameter int T_GAP = 20,
   parameter int T_CLR = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       refresh_req,
   output logic       busy,
   output logic       done,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA
);

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT,
      IDLE,
      L1_ADDR,
      L1_DATA,
      L2_ADDR,
      L2_DATA
   } state_t;

   typedef enum logic [1:0] {
      SETUP,
      PULSE,
      HOLD
   } phase_t;

   localparam logic [15:0] PWR_LAST = 16'(T_PWR - 1);
   localparam logic [15:0] SU_LAST  = 16'(T_SU - 1);
   localparam logic [15:0] EH_LAST  = 16'(T_EH - 1);
   localparam logic [15:0] GAP_LAST = 16'(T_GAP - 1);
   localparam logic [15:0] CLR_LAST = 16'(T_CLR - 1);

   state_t      state, state_n;
   phase_t      phase, phase_n;
   logic [15:0] cnt, cnt_n;
   logic [15:0] phase_last;
   logic [3:0]  idx, idx_n;
   logic        pending, pending_n;
   logic        busy_n, done_n, e_n, rs_n;
   logic [7:0]  data_n;
   logic        load, byte_end, start_frame;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_byte;
   logic [7:0]  frame_buf [32];

   assign LCD_RW = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= PWR_WAIT;
         phase    <= SETUP;
         cnt      <= '0;
         idx      <= '0;
         pending  <= 1'b0;
         busy     <= 1'b1;
         done     <= 1'b0;
         LCD_E    <= 1'b0;
         LCD_RS   <= 1'b0;
         LCD_DATA <= 8'h00;
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         pending  <= pending_n;
         busy     <= busy_n;
         done     <= done_n;
         LCD_E    <= e_n;
         LCD_RS   <= rs_n;
         LCD_DATA <= data_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            frame_buf[i] <= 8'h20;
         end
      end else if (wr_en) begin
         frame_buf[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_n     = state;
      phase_n     = phase;
      cnt_n       = cnt;
      idx_n       = idx;
      pending_n   = pending | (refresh_req && (state != IDLE));
      busy_n      = busy;
      done_n      = 1'b0;
      e_n         = LCD_E;
      rs_n        = LCD_RS;
      data_n      = LCD_DATA;
      load        = 1'b0;
      start_frame = 1'b0;
      rd_addr     = '0;
      rd_byte     = 8'h00;

      // The clear command needs a much longer post-byte gap than any other byte
      case (phase)
         SETUP:   phase_last = SU_LAST;
         PULSE:   phase_last = EH_LAST;
         default: phase_last = (!LCD_RS && (LCD_DATA == 8'h01)) ? CLR_LAST : GAP_LAST;
      endcase
      byte_end = (phase == HOLD) && (cnt == phase_last);

      case (state)
         PWR_WAIT: begin
            if (cnt == PWR_LAST) begin
               state_n = INIT;
               idx_n   = '0;
               load    = 1'b1;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         IDLE: begin
            if (refresh_req) begin
               start_frame = 1'b1;
            end
         end
         default: begin
            if (byte_end) begin
               load = 1'b1;
               case (state)
                  INIT: begin
                     if (idx == 4'd3) begin
                        load = 1'b0;
                        if (pending || refresh_req) begin
                           start_frame = 1'b1;
                        end else begin
                           state_n = IDLE;
                           busy_n  = 1'b0;
                        end
                     end else begin
                        idx_n = idx + 4'd1;
                     end
                  end
                  L1_ADDR: begin
                     state_n = L1_DATA;
                     idx_n   = '0;
                  end
                  L1_DATA: begin
                     if (idx == 4'd15) begin
                        state_n = L2_ADDR;
                        idx_n   = '0;
                     end else begin
                        idx_n = idx + 4'd1;
                     end
                  end
                  L2_ADDR: begin
                     state_n = L2_DATA;
                     idx_n   = '0;
                  end
                  L2_DATA: begin
                     if (idx == 4'd15) begin
                        load   = 1'b0;
                        done_n = 1'b1;
                        if (pending || refresh_req) begin
                           start_frame = 1'b1;
                        end else begin
                           state_n = IDLE;
                           busy_n  = 1'b0;
                        end
                     end else begin
                        idx_n = idx + 4'd1;
                     end
                  end
                  default: begin
                     load = 1'b0;
                  end
               endcase
            end else if (cnt == phase_last) begin
               cnt_n = '0;
               if (phase == SETUP) begin
                  phase_n = PULSE;
                  e_n     = 1'b1;
               end else begin
                  phase_n = HOLD;
                  e_n     = 1'b0;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
      endcase

      // A request seen while busy, or at the frame-end edge, chains straight into a new frame
      if (start_frame) begin
         state_n   = L1_ADDR;
         idx_n     = '0;
         load      = 1'b1;
         busy_n    = 1'b1;
         pending_n = 1'b0;
      end

      // A write landing on the same edge a byte is sampled is forwarded into that byte
      rd_addr = {(state_n == L2_DATA), idx_n};
      rd_byte = (wr_en && (wr_addr == rd_addr)) ? wr_data : frame_buf[rd_addr];

      if (load) begin
         phase_n = SETUP;
         cnt_n   = '0;
         e_n     = 1'b0;
         case (state_n)
            INIT: begin
               rs_n = 1'b0;
               case (idx_n)
                  4'd0:    data_n = 8'h38;
                  4'd1:    data_n = 8'h06;
                  4'd2:    data_n = 8'h0C;
                  default: data_n = 8'h01;
               endcase
            end
            L1_ADDR: begin
               rs_n   = 1'b0;
               data_n = 8'h80;
            end
            L2_ADDR: begin
               rs_n   = 1'b0;
               data_n = 8'hC0;
            end
            L1_DATA, L2_DATA: begin
               rs_n   = 1'b1;
               data_n = rd_byte;
            end
            default: begin
               rs_n   = LCD_RS;
               data_n = LCD_DATA;
            end
         endcase
      end
   end

endmodule
